// File: rtl/vga_pkg.sv
// ============================================================================
// Module  : vga_pkg
// Brief   : Shared screen geometry, colours and sprite config encodings.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

  localparam int          SCREEN_W  = 640;
  localparam int          SCREEN_H  = 480;
  localparam logic [23:0] BG_COLOR  = 24'h150088;
  localparam logic [23:0] TRANSP    = 24'hFF00FF;

  localparam int          POS_X_LSB = 0;
  localparam int          POS_Y_LSB = 16;
  localparam int          POS_W     = 10;

  localparam logic [2:0]  CFG_EN    = 3'd0;
  localparam logic [2:0]  CFG_POS0  = 3'd1;

  typedef struct packed {
    logic [POS_W-1:0] y;
    logic [POS_W-1:0] x;
  } spr_pos_t;

  function automatic spr_pos_t pos_from_data(input logic [31:0] data);
    pos_from_data.y = data[POS_Y_LSB +: POS_W];
    pos_from_data.x = data[POS_X_LSB +: POS_W];
  endfunction

endpackage

`default_nettype wire

// File: rtl/sprite_hit_unit.sv
// ============================================================================
// Module  : sprite_hit_unit
// Brief   : Combinational box test of one pixel against one sprite.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_hit_unit
  import vga_pkg::*;
#(
  parameter int SPR_LOG = 5
) (
  input  logic [POS_W-1:0]   px,
  input  logic [POS_W-1:0]   py,
  input  logic               en,
  input  logic               blank_n,
  input  logic [POS_W-1:0]   sx,
  input  logic [POS_W-1:0]   sy,
  output logic               hit,
  output logic [SPR_LOG-1:0] lx,
  output logic [SPR_LOG-1:0] ly
);

  localparam logic [POS_W:0] c_EDGE = (POS_W+1)'(1 << SPR_LOG);

  // 11-bit end coordinates so boxes near the right/bottom edge never wrap
  logic [POS_W:0] w_x_end;
  logic [POS_W:0] w_y_end;
  logic           w_in_x;
  logic           w_in_y;

  assign w_x_end = {1'b0, sx} + c_EDGE;
  assign w_y_end = {1'b0, sy} + c_EDGE;
  assign w_in_x  = (px >= sx) && ({1'b0, px} < w_x_end);
  assign w_in_y  = (py >= sy) && ({1'b0, py} < w_y_end);
  assign hit     = en && blank_n && w_in_x && w_in_y;
  assign lx      = SPR_LOG'(px - sx);
  assign ly      = SPR_LOG'(py - sy);

endmodule

`default_nettype wire

// File: rtl/sprite_compositor.sv
// ============================================================================
// Module  : sprite_compositor
// Brief   : Frame-atomic sprite config, priority hit test, 3-stage compositor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_compositor
  import vga_pkg::*;
#(
  parameter int          NSPR     = 4,
  parameter int          SPR_LOG  = 5,
  parameter logic [23:0] BG_COLOR = vga_pkg::BG_COLOR,
  parameter logic [23:0] TRANSP   = vga_pkg::TRANSP
) (
  input  logic        iVGA_CLK,
  input  logic        iRST_n,
  input  logic [9:0]  iPX,
  input  logic [9:0]  iPY,
  input  logic        iBLANK_n,
  input  logic        iVS,
  input  logic        cfg_wr,
  input  logic [2:0]  cfg_sel,
  input  logic [31:0] cfg_data,
  output logic        cfg_pending,
  output logic [11:0] rom_addr,
  input  logic [23:0] rom_q,
  output logic [23:0] oBGR
);

  localparam int ID_W = (NSPR > 1) ? $clog2(NSPR) : 1;

  logic              r_vs_d;
  logic              r_commit;
  logic [NSPR-1:0]   r_pend_en;
  spr_pos_t          r_pend_pos [NSPR];
  logic [NSPR-1:0]   r_en;
  spr_pos_t          r_pos      [NSPR];

  logic              w_wr_valid;
  logic              w_unused_cfg;

  logic [NSPR-1:0]   w_hit;
  logic [SPR_LOG-1:0] w_lx [NSPR];
  logic [SPR_LOG-1:0] w_ly [NSPR];
  logic [ID_W-1:0]   w_win;
  logic              w_any;

  logic              r_hit_d1, r_hit_d2, r_hit_d3;
  logic              r_blank_d1, r_blank_d2, r_blank_d3;
  logic [23:0]       r_q;

  assign w_wr_valid   = cfg_wr && (cfg_sel <= 3'(NSPR));
  assign w_unused_cfg = &{1'b0, cfg_data[31:26], cfg_data[15:10]};

  // Pending regs take writes; committed regs copy them the cycle after iVS falls.
  // Nonblocking semantics mean a write landing on the commit cycle waits a frame.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_vs_d      <= 1'b1;
      r_commit    <= 1'b0;
      r_pend_en   <= '0;
      r_en        <= '0;
      cfg_pending <= 1'b0;
      for (int i = 0; i < NSPR; i++) begin
        r_pend_pos[i] <= '0;
        r_pos[i]      <= '0;
      end
    end else begin
      r_vs_d   <= iVS;
      r_commit <= r_vs_d && !iVS;
      if (r_commit) begin
        r_en <= r_pend_en;
        for (int i = 0; i < NSPR; i++) r_pos[i] <= r_pend_pos[i];
      end
      if (w_wr_valid) begin
        if (cfg_sel == CFG_EN) r_pend_en <= cfg_data[NSPR-1:0];
        for (int i = 0; i < NSPR; i++) begin
          if (cfg_sel == 3'(int'(CFG_POS0) + i)) r_pend_pos[i] <= pos_from_data(cfg_data);
        end
      end
      if (w_wr_valid)    cfg_pending <= 1'b1;
      else if (r_commit) cfg_pending <= 1'b0;
    end
  end

  generate
    for (genvar g = 0; g < NSPR; g++) begin : g_hit
      sprite_hit_unit #(
        .SPR_LOG (SPR_LOG)
      ) u_hit (
        .px      (iPX),
        .py      (iPY),
        .en      (r_en[g]),
        .blank_n (iBLANK_n),
        .sx      (r_pos[g].x),
        .sy      (r_pos[g].y),
        .hit     (w_hit[g]),
        .lx      (w_lx[g]),
        .ly      (w_ly[g])
      );
    end
  endgenerate

  // Scan from the top index down so the lowest hitting index is left in w_win
  always_comb begin
    w_win = '0;
    w_any = |w_hit;
    for (int i = NSPR - 1; i >= 0; i--) begin
      if (w_hit[i]) w_win = ID_W'(i);
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      rom_addr   <= '0;
      r_hit_d1   <= 1'b0;
      r_hit_d2   <= 1'b0;
      r_hit_d3   <= 1'b0;
      r_blank_d1 <= 1'b0;
      r_blank_d2 <= 1'b0;
      r_blank_d3 <= 1'b0;
      r_q        <= '0;
    end else begin
      if (w_any) rom_addr <= {w_win, w_ly[w_win], w_lx[w_win]};
      r_hit_d1   <= w_any;
      r_blank_d1 <= iBLANK_n;
      r_hit_d2   <= r_hit_d1;
      r_blank_d2 <= r_blank_d1;
      r_hit_d3   <= r_hit_d2;
      r_blank_d3 <= r_blank_d2;
      r_q        <= rom_q;
    end
  end

  always_comb begin
    oBGR = 24'h000000;
    if (r_blank_d3) oBGR = (r_hit_d3 && (r_q != TRANSP)) ? r_q : BG_COLOR;
  end

endmodule

`default_nettype wire

// File: tb/tb_sprite_compositor.sv
// ============================================================================
// Module  : tb_sprite_compositor
// Brief   : Directed scoreboard bench for the sprite compositor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sprite_compositor;

  localparam logic [23:0] c_BG = 24'h150088;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [9:0]  iPX = '0;
  logic [9:0]  iPY = '0;
  logic        iBLANK_n = 1'b0;
  logic        iVS = 1'b1;
  logic        cfg_wr = 1'b0;
  logic [2:0]  cfg_sel = '0;
  logic [31:0] cfg_data = '0;
  logic        cfg_pending;
  logic [11:0] rom_addr;
  logic [23:0] rom_q = '0;
  logic [23:0] oBGR;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          v;
    bit          ca;
    logic [11:0] ea;
    logic [23:0] eb;
    string       nm;
  } ent_t;

  ent_t exp_q[$];

  sprite_compositor dut (
    .iVGA_CLK    (clk),
    .iRST_n      (rst_n),
    .iPX         (iPX),
    .iPY         (iPY),
    .iBLANK_n    (iBLANK_n),
    .iVS         (iVS),
    .cfg_wr      (cfg_wr),
    .cfg_sel     (cfg_sel),
    .cfg_data    (cfg_data),
    .cfg_pending (cfg_pending),
    .rom_addr    (rom_addr),
    .rom_q       (rom_q),
    .oBGR        (oBGR)
  );

  always #5 clk = ~clk;

  // Bench ROM: two special texels, otherwise a tag plus the address
  function automatic logic [23:0] rom_model(input logic [11:0] a);
    if (a == 12'h945)      return 24'hFF00FF;
    else if (a == 12'h946) return 24'h00FF00;
    else                   return {12'hC00, a};
  endfunction

  always @(posedge clk) rom_q <= rom_model(rom_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pos(input int x, input int y);
    return (32'(y) << 16) | 32'(x);
  endfunction

  task automatic pix(input int x, input int y, input bit ca, input logic [11:0] ea,
                     input logic [23:0] eb, input string nm);
    ent_t e;
    @(negedge clk);
    iPX = 10'(x); iPY = 10'(y); iBLANK_n = 1'b1;
    e.v = 1'b1; e.ca = ca; e.ea = ea; e.eb = eb; e.nm = nm;
    exp_q.push_back(e);
  endtask

  task automatic pix_blank(input string nm);
    ent_t e;
    @(negedge clk);
    iPX = 10'd100; iPY = 10'd100; iBLANK_n = 1'b0;
    e.v = 1'b1; e.ca = 1'b0; e.ea = '0; e.eb = 24'h0; e.nm = nm;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    iBLANK_n = 1'b0; iPX = '0; iPY = '0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] sel, input logic [31:0] data);
    @(negedge clk);
    cfg_wr = 1'b1; cfg_sel = sel; cfg_data = data;
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  task automatic vs_pulse();
    @(negedge clk);
    iVS = 1'b0;
    repeat (3) @(negedge clk);
    iVS = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Monitor: pixel popped at edge E is checked on rom_addr now, on oBGR two edges later
  initial begin
    ent_t d0, d1, d2;
    d0.v = 1'b0; d1.v = 1'b0; d2.v = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      d2 = d1;
      d1 = d0;
      if (exp_q.size() > 0) d0 = exp_q.pop_front();
      else                  d0.v = 1'b0;
      if (d0.v && d0.ca) chk({d0.nm, "_addr"}, 32'(rom_addr), 32'(d0.ea));
      if (d2.v)          chk({d2.nm, "_bgr"}, 32'(oBGR), 32'(d2.eb));
    end
  end

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_bgr", 32'(oBGR), 32'h0);
    chk("rst_pend", 32'(cfg_pending), 32'h0);
    chk("rst_addr", 32'(rom_addr), 32'h0);
    rst_n = 1'b1;
    idle(2);

    pix(100, 100, 1'b0, '0, c_BG, "noconf_bg");
    pix_blank("noconf_blank");
    idle(4);

    wr(3'd5, 32'hFFFF_FFFF);
    chk("sel5_pend", 32'(cfg_pending), 32'h0);

    wr(3'd1, pos(200, 50));
    wr(3'd0, 32'h1);
    chk("wr_pend", 32'(cfg_pending), 32'h1);
    pix(210, 60, 1'b0, '0, c_BG, "precommit_bg");
    idle(4);
    vs_pulse();
    chk("commit_pend", 32'(cfg_pending), 32'h0);
    pix(210, 60, 1'b1, 12'h14A, rom_model(12'h14A), "spr0");
    idle(4);

    wr(3'd1, pos(300, 300));
    wr(3'd2, pos(300, 300));
    wr(3'd0, 32'h3);
    vs_pulse();
    pix(305, 305, 1'b1, 12'h0A5, rom_model(12'h0A5), "ovl_s0");
    idle(4);
    wr(3'd0, 32'h2);
    vs_pulse();
    pix(305, 305, 1'b1, 12'h4A5, rom_model(12'h4A5), "ovl_s1");
    idle(4);

    wr(3'd3, pos(620, 100));
    wr(3'd0, 32'h4);
    vs_pulse();
    pix(619, 110, 1'b0, '0, c_BG, "edge619");
    pix(620, 110, 1'b1, 12'h940, rom_model(12'h940), "edge620");
    pix(639, 110, 1'b1, 12'h953, rom_model(12'h953), "edge639");
    pix(651, 110, 1'b1, 12'h95F, rom_model(12'h95F), "edge651");
    pix(652, 110, 1'b0, '0, c_BG, "edge652");
    pix(0, 110, 1'b0, '0, c_BG, "edge0");
    pix(625, 110, 1'b1, 12'h945, c_BG, "transp");
    pix(626, 110, 1'b1, 12'h946, 24'h00FF00, "green");
    idle(4);

    wr(3'd0, 32'h1);
    vs_pulse();
    @(negedge clk);
    iVS = 1'b0;
    @(negedge clk);
    cfg_wr = 1'b1; cfg_sel = 3'd1; cfg_data = pos(400, 300);
    @(negedge clk);
    cfg_wr = 1'b0;
    repeat (2) @(negedge clk);
    iVS = 1'b1;
    repeat (2) @(negedge clk);
    chk("simul_pend", 32'(cfg_pending), 32'h1);
    pix(305, 305, 1'b1, 12'h0A5, rom_model(12'h0A5), "simul_oldx");
    pix(405, 305, 1'b0, '0, c_BG, "simul_newx_bg");
    idle(4);
    vs_pulse();
    chk("simul_pend2", 32'(cfg_pending), 32'h0);
    pix(405, 305, 1'b1, 12'h0A5, rom_model(12'h0A5), "next_newx");
    pix(305, 305, 1'b0, '0, c_BG, "next_oldx_bg");
    idle(4);

    wr(3'd0, 32'hF);
    pix(405, 305, 1'b0, '0, rom_model(12'h0A5), "prerst");
    idle(5);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_bgr", 32'(oBGR), 32'h0);
    chk("midrst_addr", 32'(rom_addr), 32'h0);
    chk("midrst_pend", 32'(cfg_pending), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    pix(405, 305, 1'b0, '0, c_BG, "postrst_bg");
    pix_blank("postrst_blank");
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Per-pixel sprite scheduler between the VGA sync/address generator and the colour output latch in the VGA controller.
- Holds processor-written sprite configuration (enable mask from register $30, sprite positions) in pending registers and commits it atomically at frame start, so there is no tearing.
- Each visible pixel is checked against up to NSPR sprite boxes. The highest-priority hit gets the single shared sprite ROM port.
- Output is the 24-bit BGR colour: sprite texel, or background colour when there is no hit or the texel is transparent.

Parameters:
- NSPR, 4, number of sprites (sprite id width = 2).
- SPR_LOG, 5, log2 of sprite edge; sprites are 32x32 pixels.
- BG_COLOR, 24'h150088, background BGR.
- TRANSP, 24'hFF00FF, texel value treated as transparent.

Ports:
- iVGA_CLK  in  1  pixel clock; all logic on its rising edge.
- iRST_n  in  1  asynchronous active-low reset.
- iPX  in  10  current pixel column, 0..639.
- iPY  in  10  current pixel row, 0..479.
- iBLANK_n  in  1  high while (iPX, iPY) is visible.
- iVS  in  1  vertical sync, active-low.
- cfg_wr  in  1  one-cycle write strobe, already synchronised to iVGA_CLK.
- cfg_sel  in  3  0 = enable mask (cfg_data[NSPR-1:0]); 1..NSPR = position of sprite sel-1, {y[25:16], x[9:0]}; 5..7 ignored.
- cfg_data  in  32  write data.
- cfg_pending  out  1  high from an accepted write until the next commit.
- rom_addr  out  12  {sprite_id[1:0], ly[4:0], lx[4:0]}, to the synchronous sprite ROM.
- rom_q  in  24  ROM data; valid one cycle after rom_addr.
- oBGR  out  24  composited pixel colour.

Behaviour:
- Reset (async, iRST_n=0): all pending/committed regs 0, enable mask 0, cfg_pending=0, rom_addr=0, oBGR=0, pipeline valid bits 0.
- Config write: on cfg_wr with sel 0..4, load the pending register and set cfg_pending=1. Sel 5..7: no effect, and cfg_pending is unchanged.
- Commit:
  - Internal edge detector on iVS; the commit is the cycle after iVS goes 1->0.
  - On commit, copy all pending regs to committed regs and clear cfg_pending.
- Simultaneous cfg_wr and commit:
  - The commit copies the pending values from before this write.
  - The write lands in pending; cfg_pending stays 1 and the write takes effect at the next frame.
- Hit test (stage 1, combinational from inputs):
  - hit_i = en[i] & iBLANK_n & (iPX >= sx_i) & ({1'b0,iPX} < sx_i + 32) & (iPY >= sy_i) & ({1'b0,iPY} < sy_i + 32).
  - Sums are 11-bit, so there is no wrap. Boxes crossing x=640 or y=480 clip naturally.
- Priority: lowest index wins (sprite 0 on top). win_id = index of the winning sprite; any_hit = OR of hits.
- Pipeline (latency 3 from pixel inputs to oBGR):
  - t+1: register rom_addr = {win_id, iPY-sy, iPX-sx} (low 5 bits), any_hit_d1, blank_d1. When no hit, rom_addr holds its previous value.
  - t+2: rom_q valid; register any_hit_d2, blank_d2, and rom_q.
  - t+3: oBGR = !blank_d3 ? 0 : (any_hit_d3 && q != TRANSP) ? q : BG_COLOR.
- A transparent texel of the winning sprite shows BG_COLOR. Lower-priority sprites are not shown through it; this is a documented limitation.
- A commit mid-line takes effect for pixels entering stage 1 after the commit cycle. Pixels already in the pipeline keep their old results.
- Reset mid-frame: outputs go to 0 immediately. After release, the enable mask is 0, so oBGR shows background only until config is written and committed.

Decomposition:
- Package vga_pkg: SCREEN_W=640, SCREEN_H=480, BG_COLOR, TRANSP, sprite position field offsets, and cfg_sel encodings (CFG_EN=0, CFG_POS0=1).
- Sub-module sprite_hit_unit: one instance per sprite. Input is px/py/enable/position; outputs are hit plus 5-bit lx/ly. It is purely combinational and feeds the priority encoder in the top.

Test Plan:
- Reset, no config: at iBLANK_n=1, px=100, py=100 -> oBGR=24'h150088 three cycles later. When iBLANK_n=0 -> oBGR=0.
- Write en=4'b0001, pos0={y=50, x=200}, with no iVS edge:
  - cfg_pending=1, and pixel (210,60) still gives background.
  - After the iVS fall, cfg_pending=0. Pixel (210,60) -> rom_addr={2'd0, 5'd10, 5'd10} at t+1, and oBGR=rom_q at t+3.
- Overlap: sprites 0 and 1 both at (300,300), en=4'b0011:
  - Pixel (305,305) -> rom_addr[11:10]=0.
  - Disable sprite 0 and commit -> rom_addr[11:10]=1.
- Edges: sprite at x=620, with pixels 619, 620, 639 and 651 (651 never occurs on screen) -> hits are 0, 1, 1, and no wrap to column 0. Pixel (0, y) gives no hit.
- Transparency: ROM returns 24'hFF00FF for a hit pixel -> oBGR=BG_COLOR. ROM returns 24'h00FF00 -> oBGR=24'h00FF00.
- cfg_wr of pos0 (x=400) in the same cycle as a commit:
  - The committed x stays at the old value and cfg_pending stays 1.
  - After the next iVS fall, the committed x is 400.
